// File: rtl/csr_exc_file.sv
// Exception/interrupt CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY, exception entry/return, redirect.
// Optional timer (TID/TCFG/TVAL/TICLR) compiled in with `define CSR_TIMER_EN.
module csr_exc_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_we,
  input  logic [31:0] csr_wdata,
  input  logic        ecode_we,
  input  logic [6:0]  ecode_in,
  input  logic        era_we,
  input  logic [31:0] era_in,
  input  logic        badv_we,
  input  logic [31:0] badv_in,
  input  logic        store_state,
  input  logic        restore_state,
  input  logic        eentry_en,
  input  logic        era_en,
  input  logic [7:0]  ext_int,
  output logic [31:0] redirect_pc,
  output logic        redirect_valid,
  output logic [1:0]  plv,
  output logic        ie,
  output logic        int_pending
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 14;

  localparam logic [AW-1:0] A_CRMD   = AW'(14'h000);
  localparam logic [AW-1:0] A_PRMD   = AW'(14'h001);
  localparam logic [AW-1:0] A_ECFG   = AW'(14'h004);
  localparam logic [AW-1:0] A_ESTAT  = AW'(14'h005);
  localparam logic [AW-1:0] A_ERA    = AW'(14'h006);
  localparam logic [AW-1:0] A_BADV   = AW'(14'h007);
  localparam logic [AW-1:0] A_EENTRY = AW'(14'h00C);

  localparam logic [DW-1:0] M_CRMD   = DW'(32'h0000_01FF);
  localparam logic [DW-1:0] M_PRMD   = DW'(32'h0000_0007);
  localparam logic [DW-1:0] M_ECFG   = DW'(32'h0000_1FFF);
  localparam logic [DW-1:0] M_ESTAT  = DW'(32'h0000_0003);
  localparam logic [DW-1:0] M_EENTRY = DW'(32'hFFFF_FFC0);
  localparam logic [DW-1:0] M_ALL    = DW'(32'hFFFF_FFFF);
  localparam logic [DW-1:0] CRMD_RST = DW'(32'h0000_0008);

  logic [DW-1:0] crmd_q, crmd_d;
  logic [DW-1:0] prmd_q, prmd_d;
  logic [DW-1:0] ecfg_q, ecfg_d;
  logic [DW-1:0] estat_q, estat_d;
  logic [DW-1:0] era_q, era_d;
  logic [DW-1:0] badv_q, badv_d;
  logic [DW-1:0] eentry_q, eentry_d;

  // Masked software write restricted to the writable field mask.
  function automatic logic [DW-1:0] mwr(input logic [DW-1:0] old, input logic [DW-1:0] we,
                                        input logic [DW-1:0] wd, input logic [DW-1:0] fmask);
    logic [DW-1:0] m;
    m = we & fmask;
    return (old & ~m) | (wd & m);
  endfunction

  // Core CSR next-state: software write first, hardware updates override touched fields.
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    estat_d  = estat_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;

    if (csr_waddr == A_CRMD)   crmd_d   = mwr(crmd_q, csr_we, csr_wdata, M_CRMD);
    if (csr_waddr == A_PRMD)   prmd_d   = mwr(prmd_q, csr_we, csr_wdata, M_PRMD);
    if (csr_waddr == A_ECFG)   ecfg_d   = mwr(ecfg_q, csr_we, csr_wdata, M_ECFG);
    if (csr_waddr == A_ESTAT)  estat_d  = mwr(estat_q, csr_we, csr_wdata, M_ESTAT);
    if (csr_waddr == A_ERA)    era_d    = mwr(era_q, csr_we, csr_wdata, M_ALL);
    if (csr_waddr == A_BADV)   badv_d   = mwr(badv_q, csr_we, csr_wdata, M_ALL);
    if (csr_waddr == A_EENTRY) eentry_d = mwr(eentry_q, csr_we, csr_wdata, M_EENTRY);

    if (store_state) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
    end else if (restore_state) begin
      crmd_d[2:0] = prmd_q[2:0];
    end

    estat_d[9:2] = ext_int;
    if (ecode_we) estat_d[22:16] = ecode_in;
    if (era_we)   era_d  = era_in;
    if (badv_we)  badv_d = badv_in;
  end

`ifdef CSR_TIMER_EN
  localparam logic [AW-1:0] A_TID   = AW'(14'h040);
  localparam logic [AW-1:0] A_TCFG  = AW'(14'h041);
  localparam logic [AW-1:0] A_TVAL  = AW'(14'h042);
  localparam logic [AW-1:0] A_TICLR = AW'(14'h044);

  logic [DW-1:0] tid_q, tid_d;
  logic [DW-1:0] tcfg_q, tcfg_d;
  logic [DW-1:0] tval_q, tval_d;
  logic          timer_fire;
  logic          ticlr_clr;
  logic          tcfg_wr;

  // Timer countdown; a TCFG write reloads TVAL from the merged new TCFG.
  always_comb begin
    tid_d      = tid_q;
    tcfg_d     = tcfg_q;
    tval_d     = tval_q;
    timer_fire = 1'b0;
    tcfg_wr    = (csr_waddr == A_TCFG) && (csr_we != '0);
    ticlr_clr  = (csr_waddr == A_TICLR) && csr_we[0] && csr_wdata[0];

    if (csr_waddr == A_TID) tid_d = mwr(tid_q, csr_we, csr_wdata, M_ALL);
    if (tcfg_wr)            tcfg_d = mwr(tcfg_q, csr_we, csr_wdata, M_ALL);

    if (tcfg_wr) begin
      tval_d = {tcfg_d[31:2], 2'b00};
    end else if (tcfg_q[0] && (tval_q != '0)) begin
      if (tval_q == DW'(1)) begin
        timer_fire = 1'b1;
        tval_d     = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : '0;
      end else begin
        tval_d = tval_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tid_q  <= '0;
      tcfg_q <= '0;
      tval_q <= '0;
    end else begin
      tid_q  <= tid_d;
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  logic estat11_d;
  assign estat11_d = timer_fire | (estat_q[11] & ~ticlr_clr);
`else
  logic estat11_d;
  assign estat11_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_q   <= CRMD_RST;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= {estat_d[31:12], estat11_d, estat_d[10:0]};
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
    end
  end

  // Read mux reflects registered state, so a same-cycle write is not yet visible.
  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      A_CRMD:   csr_rdata = crmd_q;
      A_PRMD:   csr_rdata = prmd_q;
      A_ECFG:   csr_rdata = ecfg_q;
      A_ESTAT:  csr_rdata = estat_q;
      A_ERA:    csr_rdata = era_q;
      A_BADV:   csr_rdata = badv_q;
      A_EENTRY: csr_rdata = eentry_q;
`ifdef CSR_TIMER_EN
      A_TID:    csr_rdata = tid_q;
      A_TCFG:   csr_rdata = tcfg_q;
      A_TVAL:   csr_rdata = tval_q;
      A_TICLR:  csr_rdata = '0;
`endif
      default:  csr_rdata = '0;
    endcase
  end

  assign redirect_valid = eentry_en | era_en;
  assign redirect_pc    = eentry_en ? eentry_q : (era_en ? era_q : '0);
  assign plv            = crmd_q[1:0];
  assign ie             = crmd_q[2];
  assign int_pending    = crmd_q[2] & (|(estat_q[12:0] & ecfg_q[12:0]));

endmodule

// File: tb/tb_csr_exc_file.sv
// Directed bench for csr_exc_file: masked-write vector table plus exception, redirect, interrupt and timer sequences.
module tb_csr_exc_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_we, csr_wdata;
  logic        ecode_we, era_we, badv_we;
  logic [6:0]  ecode_in;
  logic [31:0] era_in, badv_in;
  logic        store_state, restore_state, eentry_en, era_en;
  logic [7:0]  ext_int;
  logic [31:0] redirect_pc;
  logic        redirect_valid;
  logic [1:0]  plv;
  logic        ie, int_pending;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CSR_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  csr_exc_file dut (
    .clk(clk), .rst(rst),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .ecode_we(ecode_we), .ecode_in(ecode_in),
    .era_we(era_we), .era_in(era_in),
    .badv_we(badv_we), .badv_in(badv_in),
    .store_state(store_state), .restore_state(restore_state),
    .eentry_en(eentry_en), .era_en(era_en),
    .ext_int(ext_int),
    .redirect_pc(redirect_pc), .redirect_valid(redirect_valid),
    .plv(plv), .ie(ie), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] waddr;
    logic [31:0] we;
    logic [31:0] wdata;
    logic [13:0] raddr;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a, input string name, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
    csr_waddr = a; csr_we = m; csr_wdata = d;
    tick();
    csr_we = '0; csr_waddr = 14'h3FFF;
  endtask

  vec_t vt[14];

  initial begin
    rst = 1'b1;
    csr_raddr = '0; csr_waddr = 14'h3FFF; csr_we = '0; csr_wdata = '0;
    ecode_we = 0; ecode_in = '0; era_we = 0; era_in = '0; badv_we = 0; badv_in = '0;
    store_state = 0; restore_state = 0; eentry_en = 0; era_en = 0; ext_int = '0;

    // Reset state, redirect follows inputs during reset
    #2;
    eentry_en = 1;
    rd(14'h000, "reset_crmd", 32'h8);
    check("reset_plv", 32'(plv), 32'h0);
    check("reset_ie", 32'(ie), 32'h0);
    check("reset_intp", 32'(int_pending), 32'h0);
    check("reset_rv", 32'(redirect_valid), 32'h1);
    check("reset_rpc", redirect_pc, 32'h0);
    eentry_en = 0;
    tick(); tick();
    rst = 1'b0;

    vt[0]  = '{14'h000, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h000, 32'h000001FF};
    vt[1]  = '{14'h000, 32'h000000F0, 32'h00000000, 14'h000, 32'h0000010F};
    vt[2]  = '{14'h001, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h001, 32'h00000007};
    vt[3]  = '{14'h004, 32'h0000FFFF, 32'hFFFFFFFF, 14'h004, 32'h00001FFF};
    vt[4]  = '{14'h005, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h005, 32'h00000003};
    vt[5]  = '{14'h006, 32'hFFFF0000, 32'h12345678, 14'h006, 32'h12340000};
    vt[6]  = '{14'h007, 32'hFFFFFFFF, 32'hDEADBEEF, 14'h007, 32'hDEADBEEF};
    vt[7]  = '{14'h00C, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h00C, 32'hFFFFFFC0};
    vt[8]  = '{14'h003, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h003, 32'h00000000};
    vt[9]  = '{14'h100, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h000, 32'h0000010F};
    vt[10] = '{14'h042, 32'hFFFFFFFF, 32'hFFFFFFFF, 14'h042, 32'h00000000};
    vt[11] = '{14'h044, 32'hFFFFFFFF, 32'h00000001, 14'h044, 32'h00000000};
    vt[12] = '{14'h040, 32'hFFFFFFFF, 32'hA5A5A5A5, 14'h040, TIMER ? 32'hA5A5A5A5 : 32'h0};
    vt[13] = '{14'h004, 32'h0000000F, 32'h00000000, 14'h004, 32'h00001FF0};

    for (int i = 0; i < 14; i++) begin
      csr_raddr = vt[i].raddr;
      wr(vt[i].waddr, vt[i].we, vt[i].wdata);
      check($sformatf("vec%0d", i), csr_rdata, vt[i].exp);
    end

    // Asynchronous reset between clock edges
    @(negedge clk);
    rst = 1'b1;
    rd(14'h000, "async_rst_crmd", 32'h8);
    rd(14'h006, "async_rst_era", 32'h0);
    tick();
    rst = 1'b0;

    // Exception entry: save PLV/IE, record ecode and ERA
    wr(14'h000, 32'h7, 32'h7);
    check("plv_after_wr", 32'(plv), 32'h3);
    check("ie_after_wr", 32'(ie), 32'h1);
    store_state = 1; ecode_we = 1; ecode_in = 7'h0B; era_we = 1; era_in = 32'h1C000100;
    tick();
    store_state = 0; ecode_we = 0; era_we = 0;
    rd(14'h001, "entry_prmd", 32'h7);
    rd(14'h000, "entry_crmd", 32'h8);
    rd(14'h005, "entry_estat", 32'h000B0000);
    rd(14'h006, "entry_era", 32'h1C000100);

    // Return: restore PLV/IE, redirect to ERA (pre-update value)
    restore_state = 1; era_en = 1; era_we = 1; era_in = 32'h0BADF00D;
    #1;
    check("ertn_rv", 32'(redirect_valid), 32'h1);
    check("ertn_rpc", redirect_pc, 32'h1C000100);
    tick();
    restore_state = 0; era_en = 0; era_we = 0;
    rd(14'h000, "ertn_crmd", 32'hF);
    #1;
    check("idle_rv", 32'(redirect_valid), 32'h0);
    check("idle_rpc", redirect_pc, 32'h0);

    // EENTRY write; same-cycle read sees the old value; EENTRY has priority
    csr_raddr = 14'h00C;
    csr_waddr = 14'h00C; csr_we = 32'hFFFFFFFF; csr_wdata = 32'h1C008000;
    #1;
    check("eentry_old", csr_rdata, 32'h0);
    tick();
    csr_we = '0; csr_waddr = 14'h3FFF;
    rd(14'h00C, "eentry_new", 32'h1C008000);
    eentry_en = 1; era_en = 1;
    #1;
    check("prio_rpc", redirect_pc, 32'h1C008000);
    eentry_en = 0; era_en = 0;

    // Hardware ERA load beats software write in the same cycle
    era_we = 1; era_in = 32'h11111111;
    wr(14'h006, 32'hFFFFFFFF, 32'h22222222);
    era_we = 0;
    rd(14'h006, "hw_wins_era", 32'h11111111);

    // store and restore together: store wins
    store_state = 1; restore_state = 1;
    tick();
    store_state = 0; restore_state = 0;
    rd(14'h000, "st_rs_crmd", 32'h8);
    rd(14'h001, "st_rs_prmd", 32'h7);
    restore_state = 1;
    tick();
    restore_state = 0;
    check("ie_restored", 32'(ie), 32'h1);

    // Interrupt: ECFG bit2 enables ext_int[0]
    wr(14'h004, 32'hFFFFFFFF, 32'h004);
    ext_int = 8'h01;
    #1;
    check("intp_same_cycle", 32'(int_pending), 32'h0);
    tick(); tick();
    check("intp_set", 32'(int_pending), 32'h1);
    rd(14'h005, "estat_hwi", 32'h000B0004);
    wr(14'h000, 32'h4, 32'h0);
    check("intp_ie_off", 32'(int_pending), 32'h0);
    ext_int = 8'h00;
    tick();

`ifdef CSR_TIMER_EN
    // Periodic timer: InitVal 2 -> reload 8, fires 8 cycles after the write
    wr(14'h041, 32'hFFFFFFFF, 32'h0000000B);
    rd(14'h042, "tval_load", 32'h8);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("tval_cnt%0d", k), csr_rdata, 32'(8 - k));
    end
    rd(14'h005, "estat11_pre", 32'h000B0000);
    tick();
    rd(14'h005, "estat11_set", 32'h000B0800);
    rd(14'h042, "tval_reload", 32'h8);
    // Clear collides with a new fire: set wins
    for (int k = 0; k < 7; k++) tick();
    csr_raddr = 14'h042;
    #1;
    check("tval_one", csr_rdata, 32'h1);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, "estat11_setwins", 32'h000B0800);
    wr(14'h044, 32'h1, 32'h1);
    rd(14'h005, "ticlr_clear", 32'h000B0000);
    // Reset mid-countdown leaves the timer off
    wr(14'h041, 32'hFFFFFFFF, 32'h00000041);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    rd(14'h042, "rst_mid_tval", 32'h0);
    rd(14'h041, "rst_mid_tcfg", 32'h0);
`else
    wr(14'h041, 32'hFFFFFFFF, 32'h0000000B);
    rd(14'h041, "notimer_tcfg", 32'h0);
    for (int k = 0; k < 10; k++) tick();
    rd(14'h042, "notimer_tval", 32'h0);
    rd(14'h005, "notimer_estat", 32'h000B0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_exc_file.md
CSR_EXC_FILE -- requirements
Module: csr_exc_file

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), with `clk` and `rst` first:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `csr_raddr` in 14: CSR read address.
- `csr_rdata` out 32: combinational read data.
- `csr_waddr` in 14: CSR write address.
- `csr_we` in 32: per-bit write mask.
- `csr_wdata` in 32: write data.
- `ecode_we` in 1: exception commit.
- `ecode_in` in 7: ecode [5:0] plus esubcode bit [6].
- `era_we` in 1: ERA write strobe.
- `era_in` in 32: faulting PC.
- `badv_we` in 1: BADV write strobe.
- `badv_in` in 32: bad address.
- `store_state` in 1: save PLV/IE on exception entry.
- `restore_state` in 1: restore PLV/IE on ertn.
- `eentry_en` in 1: redirect to EENTRY.
- `era_en` in 1: redirect to ERA.
- `ext_int` in 8: hardware interrupt lines.
- `redirect_pc` out 32: target PC.
- `redirect_valid` out 1: redirect strobe.
- `plv` out 2: current privilege level.
- `ie` out 1: global interrupt enable.
- `int_pending` out 1: interrupt request to the pipeline.

Function
REQ-002 The block SHALL implement these CSRs at these addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-003 Software writes SHALL update only the bits set in the mask: reg <= (reg & ~csr_we) | (csr_wdata & csr_we).
- Writes SHALL be restricted to the writable fields: CRMD[8:0], PRMD[2:0], ECFG[12:0], ESTAT[1:0], ERA, BADV, EENTRY[31:6], TID, TCFG.
- TVAL SHALL be read-only.
REQ-004 A write SHALL be visible on `csr_rdata` from the next cycle; a same-cycle read SHALL return the old value.
REQ-005 A read of an unmapped address SHALL return 0, and a write to an unmapped address SHALL be ignored.
REQ-006 On `ecode_we`, ESTAT[21:16] SHALL be loaded with ecode_in[5:0] and ESTAT[22] with ecode_in[6].
REQ-007 On `era_we`, ERA SHALL be loaded with `era_in`; on `badv_we`, BADV SHALL be loaded with `badv_in`.
REQ-008 When a hardware update (REQ-006/007/009) and a software write hit the same register in the same cycle, the hardware update SHALL win for the fields it touches.
REQ-009 On `store_state`, in one cycle:
- PRMD[1:0] SHALL take CRMD.PLV and PRMD[2] SHALL take CRMD.IE;
- CRMD.PLV SHALL become 0 and CRMD.IE SHALL become 0.
REQ-010 On `restore_state`, CRMD.PLV SHALL take PRMD.PPLV and CRMD.IE SHALL take PRMD.PIE; if `restore_state` and `store_state` are both asserted, `store_state` SHALL win.
REQ-011 Redirect outputs SHALL be combinational:
- `redirect_valid` = `eentry_en` | `era_en`;
- `redirect_pc` = EENTRY when `eentry_en`, else ERA when `era_en`, else 0;
- `eentry_en` SHALL have priority, and the ERA value used SHALL be the pre-update value.
REQ-012 ESTAT[9:2] SHALL register `ext_int` every cycle, giving 1-cycle latency.
REQ-013 `int_pending` = CRMD.IE & |(ESTAT[12:0] & ECFG[12:0]), computed combinationally from registered state.
REQ-014 `plv` SHALL equal CRMD[1:0] and `ie` SHALL equal CRMD[2].

Reset
REQ-015 While `rst` is high, all registers SHALL clear asynchronously.
REQ-016 Reset values SHALL be: CRMD = 0x00000008 (DA=1); every other CSR = 0.
REQ-017 Output values in reset SHALL be: `plv`=0, `ie`=0, `int_pending`=0; `redirect_*` SHALL follow its inputs only.
REQ-018 Deasserting `rst` mid-countdown SHALL leave the timer disabled with TVAL=0.

Configuration
REQ-019 Macro CSR_TIMER_EN SHALL compile the timer in or out.
REQ-020 With CSR_TIMER_EN defined:
- A TCFG write SHALL load TVAL = {TCFG[31:2],2'b00} on the next cycle.
- While TCFG[0]=1 and TVAL≠0, TVAL SHALL decrement by 1 per cycle.
- When TVAL==1: ESTAT[11] SHALL be set, and TVAL SHALL become {InitVal,00} if TCFG[1]=1, else 0.
- TVAL==0 SHALL hold.
- A TICLR write with bit0=1 SHALL clear ESTAT[11]; TICLR SHALL read 0.
- A simultaneous set and clear of ESTAT[11] SHALL leave it set.
REQ-021 Without CSR_TIMER_EN: TID/TCFG/TVAL/TICLR SHALL read 0 and ignore writes, and ESTAT[11] SHALL be constant 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then read CRMD -> 0x00000008; `plv`=0, `ie`=0.
- Write CRMD mask 0x7, data 0x7; then `store_state` with `ecode_we` (ecode_in=0x0B), `era_we` (era_in=0x1C000100) -> PRMD=0x7, CRMD[2:0]=0, ESTAT[21:16]=0x0B, ERA=0x1C000100.
- `restore_state` next -> CRMD[2:0]=0x7; with `era_en` -> `redirect_pc`=0x1C000100, `redirect_valid`=1.
- EENTRY write 0x1C008000 with `eentry_en`=1 and `era_en`=1 -> `redirect_pc`=0x1C008000.
- ECFG=0x004, CRMD.IE=1, `ext_int`=0x01 -> `int_pending`=1 two cycles after `ext_int` rises; deasserting IE drops it next cycle.
- CSR_TIMER_EN: TCFG=0x0000000B (InitVal 2, periodic) -> ESTAT[11] set 8 cycles after write; TVAL reloads to 8; TICLR bit0 write clears it.
